serial_uart_bridge: RTL and testbench

- Sits between the processor's serial IO ports and the board UART pins.
- RX path: deserialises 8N1 frames from the pin into an RX FIFO, which drives the processor's serial_in / serial_valid_in; serial_rden_out pops it.
- TX path: serial_wren_out / serial_out push into a TX FIFO, which serialises onto the TX pin; serial_ready_in reflects TX FIFO space.

---
 rtl/serial_uart_pkg.sv | 15 +
 rtl/serial_uart_bridge_byte_fifo.sv | 68 ++++++
 rtl/serial_uart_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_uart_pkg.sv
// Shared definitions for the serial UART bridge: FSM state encoding and frame constants.
package serial_uart_pkg;

  // Both RX and TX state machines step through the same four phases of an 8N1 frame
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_uart_bridge_byte_fifo.sv
// Byte-wide show-ahead synchronous FIFO; the head entry is always visible on rdata_o.
module byte_fifo
  import serial_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wrPtr_q;
  logic [AW-1:0]             rdPtr_q;
  logic [AW:0]               count_q;
  logic [AW:0]               count_d;
  logic                      pushOk;
  logic                      popOk;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;
  // An empty FIFO presents zero so the consumer never sees stale storage
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Occupancy only moves when exactly one of push/pop is accepted
  always_comb begin
    count_d = count_q;
    if (pushOk && !popOk) begin
      count_d = count_q + 1'b1;
    end else if (popOk && !pushOk) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only readable once written
  always_ff @(posedge clock) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Bridge between the processor serial port and the board UART pins (8N1, FIFO on each path).
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] proc_rdata_out,
  output logic       proc_valid_out,
  input  logic       proc_rden_in,
  output logic       proc_ready_out,
  input  logic [7:0] proc_wdata_in,
  input  logic       proc_wren_in,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int              CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);

  logic                      rxMeta_q;
  logic                      rxSync_q;
  uart_state_e               rxState_q;
  logic [CW-1:0]             rxClkCnt_q;
  logic [2:0]                rxBitCnt_q;
  logic [UART_DATA_BITS-1:0] rxShift_q;
  logic                      rxOverrun_q;
  logic                      rxFrameErr_q;
  logic                      rxPush;
  logic                      rxEmpty;
  logic                      rxFull;

  uart_state_e               txState_q;
  logic [CW-1:0]             txClkCnt_q;
  logic [2:0]                txBitCnt_q;
  logic [UART_DATA_BITS-1:0] txShift_q;
  logic                      txOut_q;
  logic                      txPop;
  logic                      txEmpty;
  logic                      txFull;
  logic [UART_DATA_BITS-1:0] txFifoData;

  // RX pin is asynchronous to clock, so it is brought in through two flops before use
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxMeta_q <= UART_IDLE_LEVEL;
      rxSync_q <= UART_IDLE_LEVEL;
    end else begin
      rxMeta_q <= uart_rx_in;
      rxSync_q <= rxMeta_q;
    end
  end

  // A good stop bit pushes the assembled byte in the same edge the FSM returns to idle
  assign rxPush = (rxState_q == ST_STOP) && (rxClkCnt_q == BIT_LAST) && rxSync_q && !rxFull;

  // RX FSM: detect start edge, confirm at mid-bit, then sample each bit at its centre
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxState_q    <= ST_IDLE;
      rxClkCnt_q   <= '0;
      rxBitCnt_q   <= '0;
      rxShift_q    <= '0;
      rxOverrun_q  <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      case (rxState_q)
        ST_IDLE: begin
          if (!rxSync_q) begin
            rxState_q  <= ST_START;
            rxClkCnt_q <= '0;
            rxBitCnt_q <= '0;
          end
        end
        ST_START: begin
          if (rxClkCnt_q == HALF_LAST) begin
            rxClkCnt_q <= '0;
            rxState_q  <= rxSync_q ? ST_IDLE : ST_DATA;
          end else begin
            rxClkCnt_q <= rxClkCnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rxClkCnt_q == BIT_LAST) begin
            rxClkCnt_q <= '0;
            rxShift_q  <= {rxSync_q, rxShift_q[UART_DATA_BITS-1:1]};
            rxBitCnt_q <= rxBitCnt_q + 1'b1;
            if (rxBitCnt_q == LAST_BIT_IDX) begin
              rxState_q <= ST_STOP;
            end
          end else begin
            rxClkCnt_q <= rxClkCnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (rxClkCnt_q == BIT_LAST) begin
            rxClkCnt_q <= '0;
            rxState_q  <= ST_IDLE;
            if (!rxSync_q) begin
              rxFrameErr_q <= 1'b1;
            end else if (rxFull) begin
              rxOverrun_q <= 1'b1;
            end
          end else begin
            rxClkCnt_q <= rxClkCnt_q + 1'b1;
          end
        end
        default: rxState_q <= ST_IDLE;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rxFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rxPush),
    .wdata_i (rxShift_q),
    .pop_i   (proc_rden_in),
    .rdata_o (proc_rdata_out),
    .empty_o (rxEmpty),
    .full_o  (rxFull)
  );

  assign proc_valid_out   = !rxEmpty;
  assign rx_overrun_out   = rxOverrun_q;
  assign rx_frame_err_out = rxFrameErr_q;

  // Pop from idle, or at the last stop-bit cycle so queued bytes follow with no idle gap
  assign txPop = !txEmpty &&
                 ((txState_q == ST_IDLE) ||
                  ((txState_q == ST_STOP) && (txClkCnt_q == BIT_LAST)));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_txFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (proc_wren_in),
    .wdata_i (proc_wdata_in),
    .pop_i   (txPop),
    .rdata_o (txFifoData),
    .empty_o (txEmpty),
    .full_o  (txFull)
  );

  assign proc_ready_out = !txFull;

  // TX FSM: each bit, including start and stop, is held for exactly CLKS_PER_BIT cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txState_q  <= ST_IDLE;
      txClkCnt_q <= '0;
      txBitCnt_q <= '0;
      txShift_q  <= '0;
      txOut_q    <= UART_IDLE_LEVEL;
    end else begin
      case (txState_q)
        ST_IDLE: begin
          if (txPop) begin
            txShift_q  <= txFifoData;
            txOut_q    <= 1'b0;
            txClkCnt_q <= '0;
            txState_q  <= ST_START;
          end
        end
        ST_START: begin
          if (txClkCnt_q == BIT_LAST) begin
            txClkCnt_q <= '0;
            txOut_q    <= txShift_q[0];
            txShift_q  <= {1'b0, txShift_q[UART_DATA_BITS-1:1]};
            txBitCnt_q <= '0;
            txState_q  <= ST_DATA;
          end else begin
            txClkCnt_q <= txClkCnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (txClkCnt_q == BIT_LAST) begin
            txClkCnt_q <= '0;
            if (txBitCnt_q == LAST_BIT_IDX) begin
              txOut_q   <= UART_IDLE_LEVEL;
              txState_q <= ST_STOP;
            end else begin
              txOut_q    <= txShift_q[0];
              txShift_q  <= {1'b0, txShift_q[UART_DATA_BITS-1:1]};
              txBitCnt_q <= txBitCnt_q + 1'b1;
            end
          end else begin
            txClkCnt_q <= txClkCnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (txClkCnt_q == BIT_LAST) begin
            txClkCnt_q <= '0;
            if (txPop) begin
              txShift_q <= txFifoData;
              txOut_q   <= 1'b0;
              txState_q <= ST_START;
            end else begin
              txState_q <= ST_IDLE;
            end
          end else begin
            txClkCnt_q <= txClkCnt_q + 1'b1;
          end
        end
        default: txState_q <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx_out = txOut_q;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed self-checking bench for serial_uart_bridge with 4 clocks per bit and 4-deep FIFOs.
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       uart_rx_in;
  logic       uart_tx_out;
  logic [7:0] proc_rdata_out;
  logic       proc_valid_out;
  logic       proc_rden_in;
  logic       proc_ready_out;
  logic [7:0] proc_wdata_in;
  logic       proc_wren_in;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int checks;
  int errors;

  serial_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .proc_rdata_out   (proc_rdata_out),
    .proc_valid_out   (proc_valid_out),
    .proc_rden_in     (proc_rden_in),
    .proc_ready_out   (proc_ready_out),
    .proc_wdata_in    (proc_wdata_in),
    .proc_wren_in     (proc_wren_in),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  // Free-running 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a stuck run still ends with a report
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one RX frame on the pin, then leave the line idle long enough for the stop sample
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_in = bits[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx_in = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Expected pin level for each of the 40 cycles of one TX frame
  function automatic logic [39:0] framePattern(input logic [7:0] data);
    logic [9:0]  bits;
    logic [39:0] p;
    bits = {1'b1, data, 1'b0};
    for (int k = 0; k < 40; k++) begin
      p[k] = bits[k / CPB];
    end
    return p;
  endfunction

  initial begin
    logic [39:0]  obs;
    logic [199:0] stream;
    logic         allHigh;
    logic [7:0]   rxBytes [5];

    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    uart_rx_in    = 1'b1;
    proc_rden_in  = 1'b0;
    proc_wdata_in = 8'h00;
    proc_wren_in  = 1'b0;
    rxBytes       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(negedge clock);
    checkOutput("rstTx", uart_tx_out, 1'b1);
    checkOutput("rstValid", proc_valid_out, 1'b0);
    checkOutput("rstReady", proc_ready_out, 1'b1);
    checkOutput("rstRdata", proc_rdata_out, 8'h00);
    checkOutput("rstOverrun", rx_overrun_out, 1'b0);
    checkOutput("rstFrameErr", rx_frame_err_out, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // RX single frame, then pop it
    applyStimulus(8'hA5, 1'b1);
    checkOutput("rxA5Valid", proc_valid_out, 1'b1);
    checkOutput("rxA5Data", proc_rdata_out, 8'hA5);
    checkOutput("rxA5FrameErr", rx_frame_err_out, 1'b0);
    proc_rden_in = 1'b1;
    @(negedge clock);
    proc_rden_in = 1'b0;
    checkOutput("rxPopValid", proc_valid_out, 1'b0);

    // One-cycle low glitch must be rejected silently
    uart_rx_in = 1'b0;
    @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("glitchValid", proc_valid_out, 1'b0);
    checkOutput("glitchFrameErr", rx_frame_err_out, 1'b0);
    checkOutput("glitchOverrun", rx_overrun_out, 1'b0);

    // Bad stop bit drops the byte and raises the sticky frame error
    applyStimulus(8'h5A, 1'b0);
    checkOutput("ferrValid", proc_valid_out, 1'b0);
    checkOutput("ferrFlag", rx_frame_err_out, 1'b1);
    checkOutput("ferrOverrun", rx_overrun_out, 1'b0);

    // Five frames into a 4-deep FIFO: the fifth overruns
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rxBytes[i], 1'b1);
      if (i == 3) begin
        checkOutput("ovrBeforeFull", rx_overrun_out, 1'b0);
      end
    end
    checkOutput("ovrFlag", rx_overrun_out, 1'b1);
    checkOutput("ovrFrameErrSticky", rx_frame_err_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovrValid", proc_valid_out, 1'b1);
      checkOutput("ovrData", proc_rdata_out, rxBytes[i]);
      proc_rden_in = 1'b1;
      @(negedge clock);
      proc_rden_in = 1'b0;
    end
    checkOutput("ovrDrained", proc_valid_out, 1'b0);

    // TX 0x3C written at edge N: start bit from edge N+1
    proc_wdata_in = 8'h3C;
    proc_wren_in  = 1'b1;
    @(negedge clock);
    proc_wren_in = 1'b0;
    checkOutput("tx3cIdleAtN", uart_tx_out, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      obs[k] = uart_tx_out;
    end
    checkOutput("tx3cFrame", obs, framePattern(8'h3C));
    @(negedge clock);
    checkOutput("tx3cIdleAfter", uart_tx_out, 1'b1);
    repeat (4) @(negedge clock);

    // Burst: 0xFF occupies the TX FSM while 0x01..0x05 are written back-to-back
    proc_wdata_in = 8'hFF;
    proc_wren_in  = 1'b1;
    @(negedge clock);
    proc_wdata_in = 8'h01;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      stream[c] = uart_tx_out;
      if (c == 0) proc_wdata_in = 8'h02;
      if (c == 1) proc_wdata_in = 8'h03;
      if (c == 2) begin
        checkOutput("burstReadyAfter3", proc_ready_out, 1'b1);
        proc_wdata_in = 8'h04;
      end
      if (c == 3) begin
        checkOutput("burstReadyAfter4", proc_ready_out, 1'b0);
        proc_wdata_in = 8'h05;
      end
      if (c == 4) begin
        checkOutput("burstReadyAfter5", proc_ready_out, 1'b0);
        proc_wren_in = 1'b0;
      end
    end
    checkOutput("burstFrameFF", stream[39:0], framePattern(8'hFF));
    checkOutput("burstFrame01", stream[79:40], framePattern(8'h01));
    checkOutput("burstFrame02", stream[119:80], framePattern(8'h02));
    checkOutput("burstFrame03", stream[159:120], framePattern(8'h03));
    checkOutput("burstFrame04", stream[199:160], framePattern(8'h04));
    allHigh = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      allHigh = allHigh & uart_tx_out;
    end
    checkOutput("burstFifthDropped", allHigh, 1'b1);
    checkOutput("burstReadyDrained", proc_ready_out, 1'b1);

    // Reset in the middle of a TX frame with a second byte queued
    proc_wdata_in = 8'h00;
    proc_wren_in  = 1'b1;
    @(negedge clock);
    proc_wdata_in = 8'h77;
    @(negedge clock);
    proc_wren_in = 1'b0;
    repeat (12) @(negedge clock);
    checkOutput("midFrameLow", uart_tx_out, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midRstTx", uart_tx_out, 1'b1);
    checkOutput("midRstReady", proc_ready_out, 1'b1);
    checkOutput("midRstOverrun", rx_overrun_out, 1'b0);
    checkOutput("midRstFrameErr", rx_frame_err_out, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    allHigh = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      allHigh = allHigh & uart_tx_out;
    end
    checkOutput("midRstFifoEmpty", allHigh, 1'b1);
    checkOutput("midRstValid", proc_valid_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
